// File: rtl/tmds_pkg.sv
// tmds_pkg: shared types, codewords and helpers for the multi-lane TMDS encoder.
// The TERC4 table is only referenced when TMDS_ENC_TERC4_EN is defined.
package tmds_pkg;

   typedef enum logic [1:0] {
      MODE_CTRL   = 2'b00,
      MODE_VIDEO  = 2'b01,
      MODE_ISLAND = 2'b10,
      MODE_GUARD  = 2'b11
   } tmds_mode_e;

   localparam logic [9:0] CTRL_CODE_00 = 10'b1101010100;
   localparam logic [9:0] CTRL_CODE_01 = 10'b0010101011;
   localparam logic [9:0] CTRL_CODE_10 = 10'b0101010100;
   localparam logic [9:0] CTRL_CODE_11 = 10'b1010101011;

   // Guard band: GUARD_CODE_B on lanes with index mod 3 == 1, GUARD_CODE_A elsewhere.
   localparam logic [9:0] GUARD_CODE_A = 10'b1011001100;
   localparam logic [9:0] GUARD_CODE_B = 10'b0100110011;

   function automatic logic [9:0] ctrl_code(input logic [1:0] c);
      logic [9:0] code;
      case (c)
         2'b00:   code = CTRL_CODE_00;
         2'b01:   code = CTRL_CODE_01;
         2'b10:   code = CTRL_CODE_10;
         2'b11:   code = CTRL_CODE_11;
         default: code = CTRL_CODE_00;
      endcase
      return code;
   endfunction

   function automatic logic [9:0] terc4_code(input logic [3:0] nib);
      logic [9:0] code;
      case (nib)
         4'h0:    code = 10'b1010011100;
         4'h1:    code = 10'b1001100011;
         4'h2:    code = 10'b1011100100;
         4'h3:    code = 10'b1011100010;
         4'h4:    code = 10'b0101110001;
         4'h5:    code = 10'b0100011110;
         4'h6:    code = 10'b0110001110;
         4'h7:    code = 10'b0100111100;
         4'h8:    code = 10'b1011001100;
         4'h9:    code = 10'b0100111001;
         4'hA:    code = 10'b0110011100;
         4'hB:    code = 10'b1011000110;
         4'hC:    code = 10'b1010001110;
         4'hD:    code = 10'b1001110001;
         4'hE:    code = 10'b0101100011;
         4'hF:    code = 10'b1011000011;
         default: code = 10'b1010011100;
      endcase
      return code;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] d);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, d[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/tmds_lane_enc.sv
// tmds_lane_enc: stages 2 and 3 of one TMDS lane plus its running-disparity counter.
// Optional feature macro: TMDS_ENC_TERC4_EN (adds the TERC4 nibble register and lookup).
module tmds_lane_enc
   import tmds_pkg::*;
#(
   parameter int         CNT_W      = 6,
   parameter logic [9:0] GUARD_CODE = GUARD_CODE_A
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ce,
   input  tmds_mode_e mode,
   input  logic [7:0] data,
   input  logic [1:0] ctrl,
   output logic [9:0] tmds
);

   localparam logic signed [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic signed [CNT_W-1:0] CNT_TWO  = {{(CNT_W-2){1'b0}}, 2'd2};
   localparam logic signed [CNT_W-1:0] CNT_FOUR = {{(CNT_W-3){1'b0}}, 3'd4};

   logic [3:0]              n1_s;
   logic                    use_xnor_s;
   logic                    chain_s;
   logic [8:0]              q_m_s;
   logic [8:0]              q_m_r;
   tmds_mode_e              mode_r;
   logic [1:0]              ctrl_r;
`ifdef TMDS_ENC_TERC4_EN
   logic [3:0]              nib_r;
`endif
   logic [3:0]              n1q_s;
   logic signed [CNT_W-1:0] diff_s;
   logic signed [CNT_W-1:0] two_diff_s;
   logic signed [CNT_W-1:0] cnt_next_s;
   logic signed [CNT_W-1:0] cnt_r;
   logic [9:0]              tmds_next_s;
   logic [9:0]              tmds_r;

   // Transition-minimising stage: pick XOR or XNOR chain from the data popcount.
   always_comb begin
      n1_s       = popcount8(data);
      use_xnor_s = (n1_s > 4'd4) || ((n1_s == 4'd4) && (data[0] == 1'b0));
      q_m_s      = 9'b0;
      chain_s    = data[0];
      q_m_s[0]   = chain_s;
      for (int i = 1; i < 8; i++) begin
         if (use_xnor_s) begin
            chain_s = ~(chain_s ^ data[i]);
         end else begin
            chain_s = chain_s ^ data[i];
         end
         q_m_s[i] = chain_s;
      end
      q_m_s[8] = ~use_xnor_s;
   end

   // Stage-2 pipeline register: q_m plus the side information stage 3 needs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         q_m_r  <= 9'b0;
         mode_r <= MODE_CTRL;
         ctrl_r <= 2'b00;
`ifdef TMDS_ENC_TERC4_EN
         nib_r  <= 4'h0;
`endif
      end else if (ce) begin
         q_m_r  <= q_m_s;
         mode_r <= mode;
         ctrl_r <= ctrl;
`ifdef TMDS_ENC_TERC4_EN
         nib_r  <= data[3:0];
`endif
      end
   end

   // DC-balancing and codeword selection; any non-video pixel restarts disparity at zero.
   always_comb begin
      n1q_s       = popcount8(q_m_r[7:0]);
      diff_s      = {{(CNT_W-4){1'b0}}, n1q_s} - CNT_FOUR;
      two_diff_s  = diff_s + diff_s;
      cnt_next_s  = CNT_ZERO;
      tmds_next_s = ctrl_code(ctrl_r);
      case (mode_r)
         MODE_VIDEO: begin
            if ((cnt_r == CNT_ZERO) || (n1q_s == 4'd4)) begin
               tmds_next_s = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
               cnt_next_s  = cnt_r + (q_m_r[8] ? two_diff_s : -two_diff_s);
            end else if (((cnt_r > CNT_ZERO) && (n1q_s > 4'd4)) ||
                         ((cnt_r < CNT_ZERO) && (n1q_s < 4'd4))) begin
               tmds_next_s = {1'b1, q_m_r[8], ~q_m_r[7:0]};
               cnt_next_s  = cnt_r + (q_m_r[8] ? CNT_TWO : CNT_ZERO) - two_diff_s;
            end else begin
               tmds_next_s = {1'b0, q_m_r[8], q_m_r[7:0]};
               cnt_next_s  = cnt_r + two_diff_s - (q_m_r[8] ? CNT_ZERO : CNT_TWO);
            end
         end
         MODE_GUARD: begin
            tmds_next_s = GUARD_CODE;
         end
`ifdef TMDS_ENC_TERC4_EN
         MODE_ISLAND: begin
            tmds_next_s = terc4_code(nib_r);
         end
`endif
         MODE_CTRL: begin
            tmds_next_s = ctrl_code(ctrl_r);
         end
         default: begin
            tmds_next_s = ctrl_code(ctrl_r);
         end
      endcase
   end

   // Stage-3 register: output codeword and running disparity.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         tmds_r <= 10'b0;
         cnt_r  <= CNT_ZERO;
      end else if (ce) begin
         tmds_r <= tmds_next_s;
         cnt_r  <= cnt_next_s;
      end
   end

   assign tmds = tmds_r;

endmodule

// File: rtl/tmds_enc_multi.sv
// tmds_enc_multi: NUM_CH-lane TMDS encoder, 3-stage pipeline, shared mode select.
// Optional feature macro: TMDS_ENC_TERC4_EN (mode 10 emits TERC4 instead of control codes).
module tmds_enc_multi
   import tmds_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int CNT_W  = 6
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   ce,
   input  logic [1:0]             mode,
   input  logic [8*NUM_CH-1:0]    data,
   input  logic [2*NUM_CH-1:0]    ctrl,
   output logic [10*NUM_CH-1:0]   tmds
);

   tmds_mode_e          mode_r;
   logic [8*NUM_CH-1:0] data_r;
   logic [2*NUM_CH-1:0] ctrl_r;

   // Stage-1 input register shared by all lanes.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         mode_r <= MODE_CTRL;
         data_r <= {(8*NUM_CH){1'b0}};
         ctrl_r <= {(2*NUM_CH){1'b0}};
      end else if (ce) begin
         mode_r <= tmds_mode_e'(mode);
         data_r <= data;
         ctrl_r <= ctrl;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      localparam logic [9:0] LANE_GUARD = ((g % 32'sd3) == 32'sd1) ? GUARD_CODE_B : GUARD_CODE_A;

      tmds_lane_enc #(
         .CNT_W      (CNT_W),
         .GUARD_CODE (LANE_GUARD)
      ) u_lane (
         .clock   (clock),
         .reset_n (reset_n),
         .ce      (ce),
         .mode    (mode_r),
         .data    (data_r[8*g +: 8]),
         .ctrl    (ctrl_r[2*g +: 2]),
         .tmds    (tmds[10*g +: 10])
      );
   end

endmodule
